// File: rtl/mcu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_pkg
//  Description : Shared MCU constants: ALU function codes, default datapath
//                width and the multiplier FSM state encoding. The instruction
//                controller imports the same constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcu_pkg;

    // Default operand width; ALU results are twice this wide
    localparam int MCU_WIDTH = 16;

    // ALU function codes; any other code is a NOP that yields zero
    localparam logic [3:0] FN_ADD = 4'b0001;
    localparam logic [3:0] FN_MUL = 4'b0011;
    localparam logic [3:0] FN_AND = 4'b0101;
    localparam logic [3:0] FN_SHL = 4'b1000;

    // Iterative multiplier FSM encoding
    localparam int         ST_W    = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // True when the code selects the multi-cycle multiply
    function automatic logic fn_is_mul(input logic [3:0] fn);
        return fn == FN_MUL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Iterative unsigned shift-add multiplier. One partial-product
//                step per cycle for WIDTH cycles, then a single DONE cycle in
//                which the finished product is presented with done high.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq
    import mcu_pkg::*;
#(
    parameter int WIDTH = MCU_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [ST_W-1:0]    r_state;
    logic [ST_W-1:0]    w_state_next;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_pp;
    logic [2*WIDTH-1:0] w_pp_sum;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;

    // Partial product plus shifted multiplicand: the long adder of the unit
    assign w_pp_sum = r_pp + r_mcand;
    assign product  = r_pp;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: IDLE -> MUL on start, MUL until the last iteration, one DONE cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)        w_state_next = ST_MUL;
            ST_MUL:  if (r_cnt == '0)  w_state_next = ST_DONE;
            ST_DONE:                   w_state_next = ST_IDLE;
            default:                   w_state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_MUL:  busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand latching and one shift-add step per MUL cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_pp     <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_pp     <= '0;
                        r_cnt    <= CNT_W'(WIDTH - 1);
                    end
                end
                ST_MUL: begin
                    if (r_mplier[0]) begin
                        r_pp <= w_pp_sum;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_unit
//  Description : MCU arithmetic/logic unit. ADD, AND, SHL and NOP complete
//                the cycle after start; MUL is delegated to the iterative
//                multiplier. Holds the result register and merges the
//                done/busy status of both paths.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_unit
    import mcu_pkg::*;
#(
    parameter int WIDTH = MCU_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           functionSelect,
    input  logic [WIDTH-1:0]     arin,
    input  logic [WIDTH-1:0]     brin,
    output logic [2*WIDTH-1:0]   dataACC,
    output logic                 busy,
    output logic                 done
);

    localparam int               SH_W      = $clog2(2 * WIDTH);
    localparam logic [WIDTH-1:0] SHL_LIMIT = WIDTH'(2 * WIDTH);

    logic                 w_accept;
    logic                 w_mul_start;
    logic                 w_single;
    logic                 w_mul_busy;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_mul_product;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_ext_a;
    logic [2*WIDTH-1:0]   w_shl;
    logic [2*WIDTH-1:0]   w_result;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_done;

    // A start is only honoured while the multiplier is idle; it is never queued
    assign w_accept    = start & ~w_mul_busy;
    assign w_mul_start = w_accept &  fn_is_mul(functionSelect);
    assign w_single    = w_accept & ~fn_is_mul(functionSelect);

    alu_mul_seq #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (arin),
        .b       (brin),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    // Single-cycle datapath: carry-out add, bitwise AND and barrel shift
    always_comb begin
        w_sum   = {1'b0, arin} + {1'b0, brin};
        w_ext_a = {{WIDTH{1'b0}}, arin};
        w_shl   = (brin >= SHL_LIMIT) ? '0 : (w_ext_a << brin[SH_W-1:0]);
        case (functionSelect)
            FN_ADD:  w_result = {{(WIDTH-1){1'b0}}, w_sum};
            FN_AND:  w_result = {{WIDTH{1'b0}}, arin & brin};
            FN_SHL:  w_result = w_shl;
            default: w_result = '0;
        endcase
    end

    // Result register: loads on single-cycle completion or on multiply DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_single;
            if (w_single) begin
                r_acc <= w_result;
            end else if (w_mul_done) begin
                r_acc <= w_mul_product;
            end
        end
    end

    // The product is already registered in the multiplier during DONE, so it
    // is forwarded there to appear in the same cycle as the done pulse
    assign dataACC = w_mul_done ? w_mul_product : r_acc;
    assign busy    = w_mul_busy;
    assign done    = r_done | w_mul_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_unit
//  Description : Self-checking bench for alu_unit: cycle-level behavioural
//                model with a per-cycle compare, directed literal checks and
//                randomized traffic including occasional resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_unit;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  fs    = 4'b0000;
    logic [15:0] arin  = 16'h0000;
    logic [15:0] brin  = 16'h0000;
    logic [31:0] dataACC;
    logic        busy;
    logic        done;

    alu_unit #(
        .WIDTH          (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .functionSelect (fs),
        .arin           (arin),
        .brin           (brin),
        .dataACC        (dataACC),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // ---------------- behavioural model ----------------
    logic [31:0] exp_acc  = 32'd0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic [31:0] mul_res  = 32'd0;
    int          mul_left = 0;   // busy cycles remaining, counting the current one

    function automatic logic [31:0] ref_single(input logic [3:0] f,
                                               input logic [15:0] a,
                                               input logic [15:0] b);
        case (f)
            4'b0001: return 32'(a) + 32'(b);
            4'b0101: return 32'(a & b);
            4'b1000: return (b >= 16'd32) ? 32'd0 : (32'(a) << b);
            default: return 32'd0;
        endcase
    endfunction

    // Model: a MUL accepted in cycle N keeps busy for 17 cycles, result in the last
    always @(posedge clk) begin
        if (rst) begin
            exp_acc  <= 32'd0;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
            mul_left <= 0;
        end else if (mul_left > 0) begin
            mul_left <= mul_left - 1;
            exp_busy <= (mul_left > 1);
            exp_done <= (mul_left == 2);
            if (mul_left == 2) exp_acc <= mul_res;
        end else if (start) begin
            if (fs == 4'b0011) begin
                mul_res  <= 32'(arin) * 32'(brin);
                mul_left <= 17;
                exp_busy <= 1'b1;
                exp_done <= 1'b0;
            end else begin
                exp_acc  <= ref_single(fs, arin, brin);
                exp_done <= 1'b1;
                exp_busy <= 1'b0;
            end
        end else begin
            exp_done <= 1'b0;
        end
    end

    // Per-cycle compare of all outputs against the model
    always @(negedge clk) begin
        if (check_en) begin
            n_vec++;
            if (dataACC !== exp_acc || busy !== exp_busy || done !== exp_done) begin
                n_err++;
                $display("FAIL model_cmp t=%0t: dataACC=%h busy=%b done=%b, expected %h %b %b",
                         $time, dataACC, busy, done, exp_acc, exp_busy, exp_done);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    // Single-cycle op: start for one cycle, check the result the next cycle
    task automatic op1(input string nm, input logic [3:0] f, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] expv);
        @(posedge clk); #1;
        start = 1'b1; fs = f; arin = a; brin = b;
        @(posedge clk); #1;
        start = 1'b0;
        lit(nm, dataACC, expv);
        lit({nm, "_done"}, {31'd0, done}, 32'd1);
        lit({nm, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Multiply: optional ignored ADD start with changed operands at N+5
    task automatic mul_run(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] prod, input logic [31:0] hold, input bit intr);
        @(posedge clk); #1;
        start = 1'b1; fs = 4'b0011; arin = a; brin = b;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (intr && k == 5) begin
                start = 1'b1; fs = 4'b0001; arin = 16'h0001; brin = 16'h0001;
            end
            if (k == 6) start = 1'b0;
            if (k == 1 || k == 16) lit("mul_busy", {31'd0, busy}, 32'd1);
            if (k == 8)  lit("mul_hold", dataACC, hold);
            if (k == 16) lit("mul_early_done", {31'd0, done}, 32'd0);
        end
        lit("mul_result", dataACC, prod);
        lit("mul_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        lit("mul_busy_clear", {31'd0, busy}, 32'd0);
        lit("mul_done_clear", {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_en = 1'b1;
        lit("reset_acc",  dataACC, 32'd0);
        lit("reset_busy", {31'd0, busy}, 32'd0);
        lit("reset_done", {31'd0, done}, 32'd0);

        // Directed single-cycle operations
        op1("add_carry", 4'b0001, 16'hFFFF, 16'h0001, 32'h0001_0000);
        op1("and",       4'b0101, 16'hF0F0, 16'h3C3C, 32'h0000_3030);
        op1("shl16",     4'b1000, 16'h8001, 16'd16,   32'h8001_0000);
        op1("shl31",     4'b1000, 16'h8001, 16'd31,   32'h8000_0000);
        op1("shl32",     4'b1000, 16'h8001, 16'd32,   32'h0000_0000);
        op1("nop0111",   4'b0111, 16'h1234, 16'h5678, 32'h0000_0000);
        op1("add_small", 4'b0001, 16'h1234, 16'h0001, 32'h0000_1235);

        // Multiplies, the first with an ignored ADD mid-flight
        mul_run(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 32'h0000_1235, 1'b1);
        mul_run(16'h1234, 16'h0000, 32'h0000_0000, 32'hFFFE_0001, 1'b0);

        // Reset in the middle of a multiply
        @(posedge clk); #1;
        start = 1'b1; fs = 4'b0011; arin = 16'h00FF; brin = 16'h0101;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 8) rst = 1'b1;
            if (k == 9) rst = 1'b0;
        end
        lit("rst_busy", {31'd0, busy}, 32'd0);
        lit("rst_acc",  dataACC, 32'd0);
        lit("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        lit("rst_no_done", {31'd0, done}, 32'd0);
        op1("add_after_rst", 4'b0001, 16'h0002, 16'h0003, 32'h0000_0005);

        // Back-to-back ADD, AND, SHL
        @(posedge clk); #1;
        start = 1'b1; fs = 4'b0001; arin = 16'h8000; brin = 16'h8000;
        @(posedge clk); #1;
        lit("b2b_add", dataACC, 32'h0001_0000);
        lit("b2b_add_done", {31'd0, done}, 32'd1);
        fs = 4'b0101; arin = 16'hF0F0; brin = 16'h3C3C;
        @(posedge clk); #1;
        lit("b2b_and", dataACC, 32'h0000_3030);
        lit("b2b_and_done", {31'd0, done}, 32'd1);
        fs = 4'b1000; arin = 16'h0003; brin = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        lit("b2b_shl", dataACC, 32'h0000_0030);
        lit("b2b_shl_done", {31'd0, done}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 4))
                0: fs = 4'b0001;
                1: fs = 4'b0011;
                2: fs = 4'b0101;
                3: fs = 4'b1000;
                default: fs = 4'($urandom);
            endcase
            arin = 16'($urandom);
            brin = (fs == 4'b1000) ? 16'($urandom_range(0, 40)) : 16'($urandom);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
